// File: rtl/ucsbece154b_bp_pkg.sv
// Shared encodings for the branch predictor: PHT counter values, FSM states
// and the PHT initialisation constant.
package ucsbece154b_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_cnt_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  localparam logic [1:0] PHT_INIT = 2'b01;

endpackage

// File: rtl/ucsbece154b_btb.sv
// Branch target buffer: direct-mapped storage with combinational tag compare,
// one write port and a per-index valid clear driven by the init sweep.
module ucsbece154b_btb
  import ucsbece154b_bp_pkg::*;
#(
  parameter int NUM_ENTRIES = 32,
  localparam int IDX_W = $clog2(NUM_ENTRIES),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic [29:0]      rd_word_i,
  output logic             hit_o,
  output logic [31:0]      target_o,
  output logic             is_jump_o,
  output logic             is_branch_o,
  input  logic             clr_en_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic             wr_en_i,
  input  logic [29:0]      wr_word_i,
  input  logic [31:0]      wr_target_i,
  input  logic             wr_is_jump_i,
  input  logic             wr_is_branch_i
);

  logic             valid_q     [NUM_ENTRIES];
  logic [TAG_W-1:0] tag_q       [NUM_ENTRIES];
  logic [31:0]      target_q    [NUM_ENTRIES];
  logic             is_jump_q   [NUM_ENTRIES];
  logic             is_branch_q [NUM_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;

  assign rd_idx = rd_word_i[IDX_W-1:0];
  assign wr_idx = wr_word_i[IDX_W-1:0];

  assign hit_o       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_word_i[29:IDX_W]);
  assign target_o    = target_q[rd_idx];
  assign is_jump_o   = is_jump_q[rd_idx];
  assign is_branch_o = is_branch_q[rd_idx];

  // Only the valid bits are swept; stale payload is harmless once invalid.
  always_ff @(posedge clk) begin
    if (clr_en_i) begin
      valid_q[clr_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !clr_en_i) begin
      tag_q[wr_idx]       <= wr_word_i[29:IDX_W];
      target_q[wr_idx]    <= wr_target_i;
      is_jump_q[wr_idx]   <= wr_is_jump_i;
      is_branch_q[wr_idx] <= wr_is_branch_i;
    end
  end

endmodule

// File: rtl/ucsbece154b_gshare_predictor.sv
// Fetch-stage branch predictor (BTB + 2-bit PHT) with a self-clearing init sweep.
// Define UCSBECE154B_GSHARE_EN for gshare indexing; otherwise the PHT is bimodal.
module ucsbece154b_gshare_predictor
  import ucsbece154b_bp_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [31:0]             pc_i,
  output logic [31:0]             BTBtarget_o,
  output logic                    BranchTaken_o,
  output logic [NUM_GHR_BITS-1:0] PHTreadaddress_o,
  output logic                    ready_o,
  input  logic                    upd_valid_i,
  input  logic [31:0]             upd_pc_i,
  input  logic [31:0]             upd_target_i,
  input  logic                    upd_is_branch_i,
  input  logic                    upd_is_jump_i,
  input  logic                    upd_taken_i,
  input  logic [NUM_GHR_BITS-1:0] PHTwriteaddress_i
);

  localparam int PHT_DEPTH = 1 << NUM_GHR_BITS;
  localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);
  localparam int SWEEP     = (NUM_BTB_ENTRIES > PHT_DEPTH) ? NUM_BTB_ENTRIES : PHT_DEPTH;
  localparam int CNT_W     = (SWEEP > 1) ? $clog2(SWEEP) : 1;

  bp_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         pht_q [PHT_DEPTH];
  logic [1:0]         pht_cur;
  logic [1:0]         pht_new;

  logic        upd_run;
  logic        upd_jump;
  logic        upd_branch;
  logic        btb_clr;
  logic        pht_clr;
  logic        btb_hit;
  logic        btb_is_jump;
  logic        btb_is_branch;
  logic        unused_pc_bits;

  assign unused_pc_bits = &{1'b0, pc_i[1:0], upd_pc_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(SWEEP - 1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o = (state_q == RUN);
  assign btb_clr = (state_q == INIT) && ({1'b0, cnt_q} < (CNT_W + 1)'(NUM_BTB_ENTRIES));
  assign pht_clr = (state_q == INIT) && ({1'b0, cnt_q} < (CNT_W + 1)'(PHT_DEPTH));

  // A jump+branch strobe is treated purely as a jump.
  assign upd_run    = reset_i && ready_o && upd_valid_i;
  assign upd_jump   = upd_run && upd_is_jump_i;
  assign upd_branch = upd_run && upd_is_branch_i && !upd_is_jump_i;

  assign pht_cur = pht_q[PHTwriteaddress_i];
  always_comb begin
    pht_new = pht_cur;
    if (upd_taken_i) begin
      if (pht_cur != ST) pht_new = pht_cur + 2'd1;
    end else begin
      if (pht_cur != SNT) pht_new = pht_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pht_clr) begin
      pht_q[cnt_q[NUM_GHR_BITS-1:0]] <= PHT_INIT;
    end else if (upd_branch) begin
      pht_q[PHTwriteaddress_i] <= pht_new;
    end
  end

`ifdef UCSBECE154B_GSHARE_EN
  logic [NUM_GHR_BITS-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_branch) ghr_d = {ghr_q[NUM_GHR_BITS-2:0], upd_taken_i};
  end

  always_ff @(posedge clk) begin
    if (!reset_i) ghr_q <= '0;
    else          ghr_q <= ghr_d;
  end

  assign PHTreadaddress_o = pc_i[NUM_GHR_BITS+1:2] ^ ghr_q;
`else
  assign PHTreadaddress_o = pc_i[NUM_GHR_BITS+1:2];
`endif

  ucsbece154b_btb #(
    .NUM_ENTRIES (NUM_BTB_ENTRIES)
  ) u_btb (
    .clk            (clk),
    .rd_word_i      (pc_i[31:2]),
    .hit_o          (btb_hit),
    .target_o       (BTBtarget_o),
    .is_jump_o      (btb_is_jump),
    .is_branch_o    (btb_is_branch),
    .clr_en_i       (btb_clr),
    .clr_idx_i      (cnt_q[BTB_IDX_W-1:0]),
    .wr_en_i        (upd_jump || (upd_branch && upd_taken_i)),
    .wr_word_i      (upd_pc_i[31:2]),
    .wr_target_i    (upd_target_i),
    .wr_is_jump_i   (upd_jump),
    .wr_is_branch_i (upd_branch)
  );

  assign BranchTaken_o = ready_o && btb_hit &&
                         (btb_is_jump || (btb_is_branch && pht_q[PHTreadaddress_o][1]));

endmodule

// File: tb/tb_ucsbece154b_gshare_predictor.sv
// Directed bench for ucsbece154b_gshare_predictor: table-driven lookups plus
// hand-written update sequences (init sweep, training, saturation, reset).
module tb_ucsbece154b_gshare_predictor;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] pc_i;
  logic [31:0] BTBtarget_o;
  logic        BranchTaken_o;
  logic [4:0]  PHTreadaddress_o;
  logic        ready_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_is_branch_i;
  logic        upd_is_jump_i;
  logic        upd_taken_i;
  logic [4:0]  PHTwriteaddress_i;

  always #5 clk = ~clk;

  ucsbece154b_gshare_predictor #(
    .NUM_BTB_ENTRIES (32),
    .NUM_GHR_BITS    (5)
  ) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .pc_i              (pc_i),
    .BTBtarget_o       (BTBtarget_o),
    .BranchTaken_o     (BranchTaken_o),
    .PHTreadaddress_o  (PHTreadaddress_o),
    .ready_o           (ready_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_target_i      (upd_target_i),
    .upd_is_branch_i   (upd_is_branch_i),
    .upd_is_jump_i     (upd_is_jump_i),
    .upd_taken_i       (upd_taken_i),
    .PHTwriteaddress_i (PHTwriteaddress_i)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          phase;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        chk_tgt;
    logic [4:0]  addr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  // Starts and ends on a falling edge; one cycle per vector.
  task automatic lookup_phase(input int ph);
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph) begin
        pc_i = vecs[i].pc;
        #1;
        chk($sformatf("p%0d_taken_pc%0h", ph, vecs[i].pc), 32'(BranchTaken_o), 32'(vecs[i].taken));
        if (vecs[i].chk_tgt)
          chk($sformatf("p%0d_target_pc%0h", ph, vecs[i].pc), BTBtarget_o, vecs[i].target);
        chk($sformatf("p%0d_raddr_pc%0h", ph, vecs[i].pc), 32'(PHTreadaddress_o), 32'(vecs[i].addr));
        @(negedge clk);
      end
    end
  endtask

  // Presents one update for exactly one rising edge; upd_valid_i stays high.
  task automatic apply_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic br,
                           input logic jmp, input logic tk, input logic [4:0] waddr);
    upd_valid_i       = 1'b1;
    upd_pc_i          = pc;
    upd_target_i      = tgt;
    upd_is_branch_i   = br;
    upd_is_jump_i     = jmp;
    upd_taken_i       = tk;
    PHTwriteaddress_i = waddr;
    @(negedge clk);
  endtask

  task automatic idle();
    upd_valid_i = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int  n;
    bit  bt_seen;
    n = 0;
    bt_seen = 1'b0;
    while (!ready_o && n < 200) begin
      if (BranchTaken_o) bt_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({name, "_ready_rose"}, 32'(ready_o), 32'd1);
    chk({name, "_init_cycles"}, 32'(n), 32'(exp_cycles));
    chk({name, "_no_taken_in_init"}, 32'(bt_seen), 32'd0);
  endtask

  task automatic chk_pht(input string name, input logic [1:0] exp);
    chk(name, 32'(dut.pht_q[16]), 32'(exp));
  endtask

  initial begin
    vecs.push_back('{1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b1, 5'd0});
    vecs.push_back('{1, 32'h0000_1100, 1'b0, 32'h0000_0200, 1'b1, 5'd0});
    vecs.push_back('{2, 32'h0000_0040, 1'b1, 32'h0000_0020, 1'b1, 5'd16});
    vecs.push_back('{3, 32'h0000_0040, 1'b0, 32'h0000_0020, 1'b1, 5'd16});
    vecs.push_back('{4, 32'h0000_0040, 1'b1, 32'h0000_0020, 1'b1, 5'd16});
    vecs.push_back('{4, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b1, 5'd0});
    vecs.push_back('{5, 32'h0000_0100, 1'b0, 32'h0000_0000, 1'b0, 5'd0});
    vecs.push_back('{6, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 5'd5});

    reset_i = 1'b0;
    pc_i    = 32'h0000_0100;
    upd_pc_i = '0;
    upd_target_i = '0;
    upd_is_branch_i = 1'b0;
    upd_is_jump_i = 1'b0;
    upd_taken_i = 1'b0;
    PHTwriteaddress_i = '0;
    idle();

    // Reset held 3 cycles, then a 32-cycle sweep.
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready_o), 32'd0);
    chk("reset_taken", 32'(BranchTaken_o), 32'd0);
    reset_i = 1'b1;
    wait_ready("por", 32);

    // Jump training and index aliasing.
    apply_upd(32'h100, 32'h200, 1'b0, 1'b1, 1'b0, 5'd0);
    idle();
    lookup_phase(1);

    // Same-cycle lookup of an entry being written sees the old contents.
    pc_i = 32'h310;
    apply_upd(32'h310, 32'h400, 1'b0, 1'b1, 1'b0, 5'd0);
    idle();
    chk("nobypass_after_write_taken", 32'(BranchTaken_o), 32'd1);
    chk("nobypass_after_write_target", BTBtarget_o, 32'h400);
    pc_i = 32'h310;
    apply_upd(32'h310, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0);
    idle();

`ifndef UCSBECE154B_GSHARE_EN
    // Bimodal branch training and saturation on PHT[16].
    chk_pht("pht_after_init", 2'b01);
    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b1, 5'd16);
    idle();
    chk_pht("pht_T1", 2'b10);
    lookup_phase(2);
    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b1, 5'd16);
    idle();
    chk_pht("pht_T2", 2'b11);
    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b1, 5'd16);
    idle();
    chk_pht("pht_T3_sat", 2'b11);

    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b0, 5'd16);
    idle();
    chk_pht("pht_N1", 2'b10);
    #1 chk("pred_N1_taken", 32'(BranchTaken_o), (pc_i == 32'h40) ? 32'd1 : 32'd0);
    @(negedge clk);
    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b0, 5'd16);
    idle();
    chk_pht("pht_N2", 2'b01);
    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b0, 5'd16);
    idle();
    chk_pht("pht_N3", 2'b00);
    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b0, 5'd16);
    idle();
    chk_pht("pht_N4_sat", 2'b00);
    lookup_phase(3);

    // Back-to-back taken updates both land.
    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b1, 5'd16);
    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b1, 5'd16);
    idle();
    chk_pht("pht_b2b", 2'b10);
    lookup_phase(4);
`else
    // GHR shifts T, N, T -> 5'b00101.
    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b1, 5'd16);
    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b0, 5'd16);
    apply_upd(32'h40, 32'h20, 1'b1, 1'b0, 1'b1, 5'd16);
    idle();
    chk("ghr_TNT", 32'(dut.ghr_q), 32'd5);
    lookup_phase(6);
`endif

    // Mid-run reset; an update attempted during the sweep must be ignored.
    reset_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    chk("midreset_ready", 32'(ready_o), 32'd0);
    repeat (4) @(negedge clk);
    apply_upd(32'h100, 32'h200, 1'b0, 1'b1, 1'b0, 5'd0);
    idle();
    wait_ready("midreset", 27);
    lookup_phase(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
